mem_access_unit: RTL and testbench



---
 rtl/mem_access_pkg.sv | 19 +
 rtl/mem_access_unit.sv | 128 ++++++++++++
 tb/tb_mem_access_unit.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/mem_access_pkg.sv
// Shared opcode, FSM state and width definitions for the memory access sequencer.
package mem_access_pkg;

  localparam int DATA_WIDTH_DFLT = 32;

  typedef enum logic [1:0] {
    OP_FETCH = 2'd0,
    OP_LOAD  = 2'd1,
    OP_STORE = 2'd2,
    OP_RSVD  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

endpackage

// File: rtl/mem_access_unit.sv
// Fetch/load/store sequencer in front of the unified ROM/RAM: one access cycle per request.
// Optional MEM_ACCESS_ALIGN_CHECK_EN turns word-misaligned addresses into error responses.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_WIDTH = mem_access_pkg::DATA_WIDTH_DFLT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_err_o,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [DATA_WIDTH-1:0] mdr_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

  state_e                state_q, state_d;
  op_e                   op_q, op_d;
  logic                  err_q, err_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [DATA_WIDTH-1:0] mdr_q, mdr_d;
  logic                  misalign;
  logic                  req_err;
  logic                  req_accept;

`ifdef MEM_ACCESS_ALIGN_CHECK_EN
  assign misalign = |req_addr_i[1:0];
`else
  assign misalign = 1'b0;
`endif

  // Error is decided once at capture so it stays fixed through ACCESS and RESP.
  assign req_err    = (op_e'(req_op_i) == OP_RSVD) || misalign;
  assign req_ready_o = (state_q == IDLE) || ((state_q == RESP) && rsp_ready_i);
  assign req_accept = req_valid_i && req_ready_o;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    err_d      = err_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_err_d  = rsp_err_q;
    rsp_data_d = rsp_data_q;
    instr_d    = instr_q;
    mdr_d      = mdr_q;

    case (state_q)
      IDLE:   if (req_valid_i) state_d = ACCESS;
      ACCESS: begin
        state_d    = RESP;
        rsp_err_d  = err_q;
        rsp_data_d = '0;
        if (!err_q) begin
          case (op_q)
            OP_FETCH: begin
              instr_d    = mem_rdata_i;
              rsp_data_d = mem_rdata_i;
            end
            OP_LOAD: begin
              mdr_d      = mem_rdata_i;
              rsp_data_d = mem_rdata_i;
            end
            default: ;
          endcase
        end
      end
      RESP:   if (rsp_ready_i) state_d = req_valid_i ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase

    if (req_accept) begin
      op_d    = op_e'(req_op_i);
      err_d   = req_err;
      addr_d  = req_addr_i;
      wdata_d = req_wdata_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= OP_FETCH;
      err_q      <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_err_q  <= 1'b0;
      rsp_data_q <= '0;
      instr_q    <= '0;
      mdr_q      <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      err_q      <= err_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_err_q  <= rsp_err_d;
      rsp_data_q <= rsp_data_d;
      instr_q    <= instr_d;
      mdr_q      <= mdr_d;
    end
  end

  // Decoded from state so an async reset drops the write strobe at once.
  assign mem_we_o    = (state_q == ACCESS) && (op_q == OP_STORE) && !err_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign instr_o     = instr_q;
  assign mdr_o       = mdr_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized bench for mem_access_unit against a transaction-level model with its own memory image.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_data, instr, mdr, mem_addr, mem_wdata, mem_rdata;
  logic        mem_we;

  logic [31:0] tb_mem    [256];
  logic [31:0] model_mem [256];
  logic [31:0] instr_m, mdr_m;
  int          total = 0;
  int          bad   = 0;
  int          we_cnt = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .reset(reset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_op_i(req_op),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_err_o(rsp_err),
    .rsp_data_o(rsp_data), .instr_o(instr), .mdr_o(mdr),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  assign mem_rdata = tb_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      tb_mem[mem_addr[9:2]] <= mem_wdata;
      we_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic scramble();
    req_op    = 2'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  // Presents one request (from IDLE or RESP), checks ACCESS and the response,
  // then holds the response for 'stall' extra cycles; leaves the DUT in RESP.
  task automatic issue(input logic [1:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int stall);
    logic        e_err, e_we;
    logic [31:0] e_data;
    int          c0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; rsp_ready = 1'b1;
    #1 chk("req_ready_accept", 32'(req_ready), 32'd1);
    c0 = we_cnt;

    e_err = (op == 2'd3);
`ifdef MEM_ACCESS_ALIGN_CHECK_EN
    if (addr[1:0] != 2'b00) e_err = 1'b1;
`endif
    e_we   = (op == 2'd2) && !e_err;
    e_data = 32'd0;
    if (!e_err) begin
      case (op)
        2'd0: begin e_data = model_mem[addr[9:2]]; instr_m = e_data; end
        2'd1: begin e_data = model_mem[addr[9:2]]; mdr_m = e_data; end
        2'd2: model_mem[addr[9:2]] = wdata;
        default: ;
      endcase
    end

    @(negedge clk);
    chk("access_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("access_we", 32'(mem_we), 32'(e_we));
    chk("access_addr", mem_addr, addr);
    chk("access_wdata", mem_wdata, wdata);
    req_valid = 1'b0; rsp_ready = 1'b0;
    scramble();

    @(negedge clk);
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(e_err));
    chk("rsp_data", rsp_data, e_data);
    chk("instr", instr, instr_m);
    chk("mdr", mdr, mdr_m);
    chk("we_pulses", 32'(we_cnt - c0), 32'(e_we));
    chk("rsp_we_low", 32'(mem_we), 32'd0);

    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1; rsp_ready = 1'b0;
      scramble();
      #1 chk("stall_req_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall_rsp_data", rsp_data, e_data);
      chk("stall_rsp_err", 32'(rsp_err), 32'(e_err));
      chk("stall_instr", instr, instr_m);
      chk("stall_mdr", mdr, mdr_m);
      chk("stall_we", 32'(mem_we), 32'd0);
    end
    req_valid = 1'b0;
  endtask

  task automatic release_rsp();
    @(negedge clk);
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    chk("release_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("release_req_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_mdr"}, mdr, 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
  endtask

  initial begin
    int          c0;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) begin
      tb_mem[i]    = $urandom;
      model_mem[i] = tb_mem[i];
    end
    tb_mem[0]    = 32'h20080005;
    model_mem[0] = 32'h20080005;
    instr_m = 32'd0; mdr_m = 32'd0;
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 2'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_reset_vals("reset");
    chk("reset_req_ready", 32'(req_ready), 32'd1);

    issue(2'd0, 32'h00400000, 32'd0, 0);
    release_rsp();
    issue(2'd2, 32'h10010004, 32'hDEADBEEF, 0);
    issue(2'd1, 32'h10010004, 32'd0, 5);
    issue(2'd0, 32'h00400000, 32'd0, 0);
    release_rsp();
    issue(2'd3, 32'h10010008, 32'h12345678, 1);
    issue(2'd2, 32'h10010002, 32'hCAFEF00D, 0);
    issue(2'd1, 32'h10010000, 32'd0, 0);
    release_rsp();

    // Reset during a store's ACCESS cycle: the write must never land.
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd2; req_addr = 32'h10010008; req_wdata = 32'h0BADCAFE;
    c0 = we_cnt;
    @(negedge clk);
    req_valid = 1'b0;
    chk("midrst_we_before", 32'(mem_we), 32'd1);
    #2 reset = 1'b1;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    reset = 1'b0;
    instr_m = 32'd0; mdr_m = 32'd0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midrst_no_rsp", 32'(rsp_valid), 32'd0);
    end
    chk("midrst_no_write", 32'(we_cnt - c0), 32'd0);
    issue(2'd1, 32'h10010008, 32'd0, 0);
    release_rsp();

    for (int n = 0; n < 40; n++) begin
      a = 32'h10010000 | ($urandom & 32'h3FF);
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      issue(2'($urandom_range(0, 3)), a, $urandom, $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) release_rsp();
    end
    release_rsp();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
